// File: rtl/gpu_copy_cv_burst.sv
// CPU-to-VRAM rectangle copy: packs a pixel stream into BLOCK_PIX-pixel blocks, one masked burst per block.
// Latency: 1 pixel/cycle in FILL, plus 2 cycles per block (stencil read + flush); o_done 1 cycle after the last flush.
// Backpressure: i_busy holds the burst and its data in FLUSH; o_pixReady drops there, so no input beat is taken.
module gpu_copy_cv_burst #(
    parameter int BLOCK_PIX = 16,
    parameter int IN_PIX    = 2,
    parameter int LOG       = $clog2(BLOCK_PIX),
    parameter int ADR_W     = 19 - LOG
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_checkMask,
    input  logic                    i_forceMask,
    input  logic [9:0]              i_x0,
    input  logic [8:0]              i_y0,
    input  logic [10:0]             i_w,
    input  logic [9:0]              i_h,
    output logic                    o_active,
    output logic                    o_done,
    input  logic                    i_pixValid,
    input  logic [16*IN_PIX-1:0]    i_pix,
    output logic                    o_pixReady,
    output logic                    o_stReadReq,
    output logic [ADR_W-1:0]        o_stReadAdr,
    input  logic [BLOCK_PIX-1:0]    i_stReadMask,
    output logic                    o_stWrite,
    output logic [ADR_W-1:0]        o_stWriteAdr,
    output logic [BLOCK_PIX-1:0]    o_stWriteSel,
    output logic [BLOCK_PIX-1:0]    o_stWriteVal,
    output logic                    o_command,
    input  logic                    i_busy,
    output logic [ADR_W-1:0]        o_adr,
    output logic [BLOCK_PIX-1:0]    o_writeMask,
    output logic [16*BLOCK_PIX-1:0] o_dataOut
);

    typedef enum logic [1:0] {S_IDLE, S_RDMASK, S_FILL, S_FLUSH} state_t;

    state_t                  state_q;
    logic [9:0]              x0_q, cx_q;
    logic [8:0]              cy_q;
    logic [10:0]             w_q, col_q;
    logic [9:0]              h_q, row_q;
    logic                    chk_q, frc_q;
    logic                    ln_q, first_q, more_q, done_q;
    logic [BLOCK_PIX-1:0]    stmask_q, wmask_q;
    logic [16*BLOCK_PIX-1:0] data_q;
    logic [ADR_W-1:0]        adr_q;

    logic [15:0]             pix_lane, pix_w;
    logic [LOG-1:0]          slot;
    logic [BLOCK_PIX-1:0]    stm, bit15;
    logic                    last_pix, row_end, new_blk, wr_en;
    logic                    has_cmd, accept, flush_done;
    logic [9:0]              cx_n;
    logic [8:0]              cy_n;

    // Lane 0 occupies the low half of the beat and is always consumed first.
    assign pix_lane = ln_q ? i_pix[16*IN_PIX-1 -: 16] : i_pix[15:0];
    assign pix_w    = {pix_lane[15] | frc_q, pix_lane[14:0]};
    assign slot     = cx_q[LOG-1:0];
    // The stencil word arrives only in the first FILL cycle; afterwards use the captured copy.
    assign stm      = first_q ? i_stReadMask : stmask_q;
    assign wr_en    = !(chk_q & stm[slot]);

    assign row_end  = (col_q == w_q - 11'd1);
    assign last_pix = row_end && (row_q == h_q - 10'd1);
    assign cx_n     = row_end ? x0_q : cx_q + 10'd1;
    assign cy_n     = row_end ? cy_q + 9'd1 : cy_q;
    // x wrap 1023->0 changes x[9:LOG], so it always opens a new block.
    assign new_blk  = (cy_n != cy_q) || (cx_n[9:LOG] != cx_q[9:LOG]);

    assign has_cmd    = |wmask_q;
    assign accept     = (state_q == S_FLUSH) && has_cmd && !i_busy;
    assign flush_done = (state_q == S_FLUSH) && (!has_cmd || !i_busy);

    assign o_active     = (state_q != S_IDLE);
    assign o_done       = done_q;
    assign o_pixReady   = (state_q == S_FILL) && i_pixValid &&
                          ((ln_q == 1'(IN_PIX-1)) || last_pix);
    assign o_stReadReq  = (state_q == S_RDMASK);
    assign o_stReadAdr  = o_stReadReq ? {cy_q, cx_q[9:LOG]} : '0;
    assign o_command    = (state_q == S_FLUSH) && has_cmd;
    assign o_adr        = o_command ? adr_q : '0;
    assign o_writeMask  = o_command ? wmask_q : '0;
    assign o_dataOut    = o_command ? data_q : '0;
    assign o_stWrite    = accept;
    assign o_stWriteAdr = accept ? adr_q : '0;
    assign o_stWriteSel = accept ? wmask_q : '0;
    assign o_stWriteVal = accept ? (wmask_q & bit15) : '0;

    // Gather the mask bit (bit 15) of every buffered pixel for the stencil update.
    always_comb begin
        bit15 = '0;
        for (int i = 0; i < BLOCK_PIX; i++) begin
            bit15[i] = data_q[16*i+15];
        end
    end

    // Control FSM with walk counters and the block assembly buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            chk_q    <= 1'b0;
            frc_q    <= 1'b0;
            ln_q     <= 1'b0;
            first_q  <= 1'b0;
            more_q   <= 1'b0;
            done_q   <= 1'b0;
            stmask_q <= '0;
            wmask_q  <= '0;
            data_q   <= '0;
            adr_q    <= '0;
        end else if (i_abort) begin
            state_q <= S_IDLE;
            wmask_q <= '0;
            done_q  <= 1'b0;
            ln_q    <= 1'b0;
            first_q <= 1'b0;
            more_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        x0_q   <= i_x0;
                        cx_q   <= i_x0;
                        cy_q   <= i_y0;
                        w_q    <= i_w;
                        h_q    <= i_h;
                        chk_q  <= i_checkMask;
                        frc_q  <= i_forceMask;
                        col_q  <= '0;
                        row_q  <= '0;
                        ln_q   <= 1'b0;
                        more_q <= 1'b1;
                        if (i_w == 11'd0 || i_h == 10'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RDMASK;
                        end
                    end
                end
                S_RDMASK: begin
                    adr_q   <= {cy_q, cx_q[9:LOG]};
                    first_q <= 1'b1;
                    state_q <= S_FILL;
                end
                S_FILL: begin
                    if (first_q) begin
                        stmask_q <= i_stReadMask;
                        first_q  <= 1'b0;
                    end
                    if (i_pixValid) begin
                        wmask_q[slot]                <= wr_en;
                        data_q[16*int'(slot) +: 16] <= pix_w;
                        ln_q  <= o_pixReady ? 1'b0 : 1'b1;
                        cx_q  <= cx_n;
                        cy_q  <= cy_n;
                        col_q <= row_end ? 11'd0 : col_q + 11'd1;
                        row_q <= row_end ? row_q + 10'd1 : row_q;
                        if (last_pix) begin
                            more_q <= 1'b0;
                        end
                        if (new_blk || last_pix) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_done) begin
                        wmask_q <= '0;
                        if (more_q) begin
                            state_q <= S_RDMASK;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_copy_cv_burst.sv
`timescale 1ns/1ps
module tb_gpu_copy_cv_burst;

    localparam int BP = 16;
    localparam int IP = 2;
    localparam int AW = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start, i_abort, i_checkMask, i_forceMask;
    logic [9:0]      i_x0;
    logic [8:0]      i_y0;
    logic [10:0]     i_w;
    logic [9:0]      i_h;
    logic            o_active, o_done;
    logic            i_pixValid;
    logic [16*IP-1:0] i_pix;
    logic            o_pixReady;
    logic            o_stReadReq;
    logic [AW-1:0]   o_stReadAdr;
    logic [BP-1:0]   i_stReadMask;
    logic            o_stWrite;
    logic [AW-1:0]   o_stWriteAdr;
    logic [BP-1:0]   o_stWriteSel, o_stWriteVal;
    logic            o_command;
    logic            i_busy;
    logic [AW-1:0]   o_adr;
    logic [BP-1:0]   o_writeMask;
    logic [16*BP-1:0] o_dataOut;

    always #5 clk = ~clk;

    gpu_copy_cv_burst #(.BLOCK_PIX(BP), .IN_PIX(IP)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_checkMask(i_checkMask), .i_forceMask(i_forceMask),
        .i_x0(i_x0), .i_y0(i_y0), .i_w(i_w), .i_h(i_h),
        .o_active(o_active), .o_done(o_done),
        .i_pixValid(i_pixValid), .i_pix(i_pix), .o_pixReady(o_pixReady),
        .o_stReadReq(o_stReadReq), .o_stReadAdr(o_stReadAdr), .i_stReadMask(i_stReadMask),
        .o_stWrite(o_stWrite), .o_stWriteAdr(o_stWriteAdr),
        .o_stWriteSel(o_stWriteSel), .o_stWriteVal(o_stWriteVal),
        .o_command(o_command), .i_busy(i_busy), .o_adr(o_adr),
        .o_writeMask(o_writeMask), .o_dataOut(o_dataOut)
    );

    typedef struct {
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [10:0] w;
        logic [9:0]  h;
        bit          chk;
        bit          frc;
        logic [15:0] sten;
        bit          gaps;
        int          busy;      // 0 never, 1 random, 2 hold each burst 10 cycles
        int          exp_cmds;
        int          exp_beats;
    } vec_t;

    typedef struct {
        logic [AW-1:0]    adr;
        logic [BP-1:0]    mask;
        logic [16*BP-1:0] data;
        logic [BP-1:0]    sval;
    } cmd_t;

    cmd_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pixv(input int k);
        return 16'(k * 4663 + 16'h3a5c);
    endfunction

    function automatic logic [16*BP-1:0] expand(input logic [BP-1:0] m);
        logic [16*BP-1:0] r;
        r = '0;
        for (int i = 0; i < BP; i++) r[16*i +: 16] = {16{m[i]}};
        return r;
    endfunction

    // Reference walk of the rectangle: one entry per block that has any enabled pixel.
    task automatic build_model(input vec_t v);
        int n, col, row, s;
        logic [9:0] xl;
        logic [8:0] yl;
        logic [AW-1:0] blk;
        logic [15:0] pv;
        cmd_t cur;
        n = int'(v.w) * int'(v.h);
        exp_q.delete();
        cur = '{default: '0};
        for (int k = 0; k < n; k++) begin
            col = k % int'(v.w);
            row = k / int'(v.w);
            xl  = 10'((int'(v.x0) + col) % 1024);
            yl  = 9'((int'(v.y0) + row) % 512);
            blk = {yl, xl[9:4]};
            if (k == 0 || blk != cur.adr) begin
                if (k != 0 && cur.mask != '0) exp_q.push_back(cur);
                cur = '{default: '0};
                cur.adr = blk;
            end
            s = int'(xl[3:0]);
            if (!(v.chk && v.sten[s])) begin
                pv = pixv(k);
                pv[15] = pv[15] | v.frc;
                cur.mask[s] = 1'b1;
                cur.data[16*s +: 16] = pv;
                cur.sval[s] = pv[15];
            end
        end
        if (n > 0 && cur.mask != '0) exp_q.push_back(cur);
    endtask

    // Called at the drive point (#1 after a rising edge); returns at the same point.
    task automatic run_case(input vec_t v, input string tag);
        int n, p, beats, cmds, hold;
        bit req_prev, fin;
        logic [AW-1:0] s_adr;
        logic [BP-1:0] s_mask;
        logic [16*BP-1:0] s_dat;
        cmd_t e;
        build_model(v);
        n = int'(v.w) * int'(v.h);
        p = 0; beats = 0; cmds = 0; hold = 0; req_prev = 0; fin = 0;
        s_adr = '0; s_mask = '0; s_dat = '0;
        i_x0 = v.x0; i_y0 = v.y0; i_w = v.w; i_h = v.h;
        i_checkMask = v.chk; i_forceMask = v.frc; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            i_pixValid   = (p < n) && !(v.gaps && (cyc % 3 == 2));
            i_pix        = {pixv(p + 1), pixv(p)};
            i_stReadMask = req_prev ? v.sten : 16'hA5C3;
            case (v.busy)
                1:       i_busy = 1'($urandom_range(0, 1));
                2:       i_busy = o_command && (hold < 10);
                default: i_busy = 1'b0;
            endcase
            @(negedge clk);
            if (o_pixReady) begin
                check({tag, " ready_needs_valid"}, i_pixValid, 1'b1);
                p += IP;
                beats++;
            end
            if (o_command && i_busy) begin
                if (hold == 0) begin
                    s_adr = o_adr; s_mask = o_writeMask; s_dat = o_dataOut;
                end else begin
                    check({tag, " hold_adr"}, o_adr, s_adr);
                    check({tag, " hold_mask"}, o_writeMask, s_mask);
                    check({tag, " hold_data"}, o_dataOut, s_dat);
                end
                check({tag, " busy_no_ready"}, o_pixReady, 1'b0);
                hold++;
            end
            if (o_command && !i_busy) begin
                hold = 0;
                cmds++;
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected_cmd_adr"}, o_adr, {AW{1'bx}});
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " cmd_adr"}, o_adr, e.adr);
                    check({tag, " cmd_mask"}, o_writeMask, e.mask);
                    check({tag, " cmd_data"}, o_dataOut & expand(e.mask), e.data);
                    check({tag, " st_write"}, o_stWrite, 1'b1);
                    check({tag, " st_adr"}, o_stWriteAdr, e.adr);
                    check({tag, " st_sel"}, o_stWriteSel, e.mask);
                    check({tag, " st_val"}, o_stWriteVal, e.sval);
                end
            end else begin
                check({tag, " stray_st_write"}, o_stWrite, 1'b0);
            end
            if (o_done) fin = 1;
            req_prev = o_stReadReq;
            @(posedge clk); #1;
        end
        check({tag, " done_seen"}, fin, 1'b1);
        check({tag, " cmd_count"}, cmds, v.exp_cmds);
        check({tag, " beat_count"}, beats, v.exp_beats);
        check({tag, " sb_empty"}, exp_q.size(), 0);
        i_pixValid = 1'b0;
        i_busy = 1'b0;
        @(negedge clk);
        check({tag, " done_one_pulse"}, o_done, 1'b0);
        check({tag, " idle_after"}, o_active, 1'b0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        int beats, p, quiet;
        //          x0    y0   w   h  chk frc sten      gaps busy cmds beats
        tbl[0]  = '{10'd0,    9'd0,   11'd16, 10'd1, 0, 0, 16'h0000, 0, 0, 1, 8};
        tbl[1]  = '{10'd5,    9'd0,   11'd4,  10'd2, 0, 0, 16'h0000, 0, 0, 2, 4};
        tbl[2]  = '{10'd1020, 9'd3,   11'd8,  10'd1, 0, 0, 16'h0000, 0, 0, 2, 4};
        tbl[3]  = '{10'd0,    9'd0,   11'd16, 10'd1, 1, 1, 16'h00FF, 0, 0, 1, 8};
        tbl[4]  = '{10'd0,    9'd0,   11'd16, 10'd1, 1, 1, 16'hFFFF, 0, 0, 0, 8};
        tbl[5]  = '{10'd0,    9'd0,   11'd3,  10'd1, 0, 0, 16'h0000, 0, 0, 1, 2};
        tbl[6]  = '{10'd0,    9'd0,   11'd0,  10'd1, 0, 0, 16'h0000, 0, 0, 0, 0};
        tbl[7]  = '{10'd4,    9'd0,   11'd5,  10'd0, 0, 0, 16'h0000, 0, 0, 0, 0};
        tbl[8]  = '{10'd1010, 9'd511, 11'd40, 10'd3, 0, 0, 16'h0000, 1, 1, 9, 60};
        tbl[9]  = '{10'd7,    9'd100, 11'd9,  10'd3, 1, 0, 16'h0F0F, 1, 0, 3, 14};
        tbl[10] = '{10'd3,    9'd7,   11'd20, 10'd1, 0, 0, 16'h0000, 0, 2, 2, 10};

        rst = 1'b1; i_start = 0; i_abort = 0; i_checkMask = 0; i_forceMask = 0;
        i_x0 = 0; i_y0 = 0; i_w = 0; i_h = 0; i_pixValid = 0; i_pix = 0;
        i_stReadMask = 0; i_busy = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_active", o_active, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_command", o_command, 1'b0);
        check("rst_stread", o_stReadReq, 1'b0);
        check("rst_stwrite", o_stWrite, 1'b0);
        check("rst_mask", o_writeMask, '0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_case(tbl[i], $sformatf("vec%0d", i));

        // Abort while filling the first block of a 32x2 rectangle.
        i_x0 = 0; i_y0 = 0; i_w = 32; i_h = 2; i_checkMask = 0; i_forceMask = 0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        beats = 0; p = 0;
        for (int c = 0; c < 200 && beats < 3; c++) begin
            i_pixValid = 1'b1;
            i_pix = {pixv(p + 1), pixv(p)};
            i_stReadMask = '0;
            @(negedge clk);
            if (o_pixReady) begin beats++; p += IP; end
            @(posedge clk); #1;
        end
        check("abort_reached_fill", beats, 3);
        i_abort = 1'b1;
        @(negedge clk);
        check("abort_same_cycle_active", o_active, 1'b1);
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_pixValid = 1'b0;
        @(negedge clk);
        check("abort_idle", o_active, 1'b0);
        check("abort_no_cmd", o_command, 1'b0);
        check("abort_no_stread", o_stReadReq, 1'b0);
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_command || o_done || o_active || o_stWrite) quiet++;
        end
        check("abort_quiet", quiet, 0);
        @(posedge clk); #1;

        // Recovery after abort: stale buffer mask would leak into this burst.
        rv = '{10'd8, 9'd0, 11'd4, 10'd1, 0, 0, 16'h0000, 0, 0, 1, 2};
        run_case(rv, "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
